// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified-memory port arbiter: FSM encoding, grant ids,
// default geometry and the round-robin pick used in IDLE.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int RAM_SIZE_BIT_DEF = 8;
  localparam int INST_WORDS_DEF   = 32;
  localparam bit PROTECT_TEXT_DEF = 1'b1;

  // Round-robin: on contention the port that did not win last time goes first.
  function automatic logic pick_grant(input logic i_req, input logic d_req, input logic last_grant);
    logic gnt;
    if (i_req && d_req) begin
      gnt = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (d_req) begin
      gnt = GNT_D;
    end else begin
      gnt = GNT_I;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_checker.sv
// Combinational legality check of a latched request: range, alignment and
// (optionally) stores into the text region.
module mem_access_checker
  import mem_port_arbiter_pkg::*;
#(
  parameter int RAM_SIZE_BIT = RAM_SIZE_BIT_DEF,
  parameter int INST_WORDS   = INST_WORDS_DEF,
  parameter bit PROTECT_TEXT = PROTECT_TEXT_DEF
) (
  input  logic [31:0] addr,
  input  logic        we,
  output logic        err
);

  logic [31:0] high_s;
  logic [31:0] word_s;
  logic        out_of_range_s;
  logic        misaligned_s;
  logic        text_store_s;

  // Masks instead of part-selects keep the check valid for any RAM_SIZE_BIT.
  always_comb begin
    high_s         = addr >> (RAM_SIZE_BIT + 2);
    word_s         = (addr & ((32'd1 << (RAM_SIZE_BIT + 2)) - 32'd1)) >> 2;
    out_of_range_s = (high_s != 32'd0);
    misaligned_s   = (addr[1:0] != 2'b00);
    text_store_s   = PROTECT_TEXT && we && (word_s < 32'(INST_WORDS));
    err            = out_of_range_s | misaligned_s | text_store_s;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between fetch (I) and load/store (D)
// using an IDLE -> SERVE -> ACK transaction with round-robin grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int RAM_SIZE_BIT = RAM_SIZE_BIT_DEF,
  parameter int INST_WORDS   = INST_WORDS_DEF,
  parameter bit PROTECT_TEXT = PROTECT_TEXT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  state_e      state_r, state_s;
  logic        start_s, grant_s, err_s;
  logic        winner_r, last_grant_r, we_r;
  logic [31:0] addr_r, wdata_r;
  logic        i_ack_r, i_err_r, d_ack_r, d_err_r, busy_r;
  logic [31:0] i_rdata_r, d_rdata_r;

  mem_access_checker #(
    .RAM_SIZE_BIT(RAM_SIZE_BIT),
    .INST_WORDS  (INST_WORDS),
    .PROTECT_TEXT(PROTECT_TEXT)
  ) u_checker (
    .addr(addr_r),
    .we  (we_r),
    .err (err_s)
  );

  // Next-state logic and arbitration.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    grant_s = pick_grant(i_req, d_req, last_grant_r);
    case (state_r)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_s = ST_SERVE;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SERVE: state_s = ST_ACK;
      ST_ACK:   state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latch the winning request; fetches never write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner_r <= GNT_I;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
      we_r     <= 1'b0;
    end else if (start_s) begin
      winner_r <= grant_s;
      addr_r   <= (grant_s == GNT_I) ? i_addr : d_addr;
      wdata_r  <= (grant_s == GNT_I) ? 32'd0 : d_wdata;
      we_r     <= (grant_s == GNT_D) && d_we;
    end
  end

  // Completion: read-data capture at SERVE->ACK, ack/err pulses, grant history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_ack_r      <= 1'b0;
      i_err_r      <= 1'b0;
      d_ack_r      <= 1'b0;
      d_err_r      <= 1'b0;
      i_rdata_r    <= 32'd0;
      d_rdata_r    <= 32'd0;
      last_grant_r <= GNT_D;
      busy_r       <= 1'b0;
    end else begin
      i_ack_r <= 1'b0;
      i_err_r <= 1'b0;
      d_ack_r <= 1'b0;
      d_err_r <= 1'b0;
      busy_r  <= (state_s != ST_IDLE);
      if (state_r == ST_SERVE) begin
        if (winner_r == GNT_I) begin
          i_ack_r   <= 1'b1;
          i_err_r   <= err_s;
          i_rdata_r <= err_s ? 32'd0 : mem_rdata;
        end else begin
          d_ack_r <= 1'b1;
          d_err_r <= err_s;
          // A clean store leaves the last load value in place.
          if (err_s || !we_r) begin
            d_rdata_r <= err_s ? 32'd0 : mem_rdata;
          end
        end
      end
      if (state_r == ST_ACK) begin
        last_grant_r <= winner_r;
      end
    end
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_read  = (state_r == ST_SERVE) && !we_r && !err_s;
  assign mem_write = (state_r == ST_SERVE) && we_r && !err_s;
  assign i_ack     = i_ack_r;
  assign i_err     = i_err_r;
  assign i_rdata   = i_rdata_r;
  assign d_ack     = d_ack_r;
  assign d_err     = d_err_r;
  assign d_rdata   = d_rdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 256-word memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy;

  logic [31:0] mem [0:255];
  logic        load_mem = 1'b0;
  int          write_count = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  // Memory model: word k preset to A500_0000|k, word 2 holds the fetch test word.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'hA500_0000 | 32'(k);
      mem[2] <= 32'h0C00_0004;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      write_count <= write_count + 1;
    end
  end

  task automatic wait_ack(input bit port_d, output int cyc);
    cyc = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if ((port_d ? d_ack : i_ack) === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic run_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata, output int cyc);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    wait_ack(1'b1, cyc);
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic run_i(input logic [31:0] addr, output int cyc);
    @(negedge clk);
    i_req = 1'b1; i_addr = addr;
    wait_ack(1'b0, cyc);
    i_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_mem = 1'b1;
    repeat (3) @(negedge clk);
    load_mem = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({i_ack, d_ack, i_err, d_err, mem_read, mem_write, busy} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000000", {i_ack, d_ack, i_err, d_err, mem_read, mem_write, busy});
    end
    n_checks++;
    if (i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", i_rdata, d_rdata);
    end
    n_checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_bus: got %h/%h want 0/0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_fetch();
    int cyc;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_0008;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h8 || busy !== 1'b1) begin
      n_fail++; $display("FAIL fetch_serve: got rd=%b addr=%h busy=%b want 1/8/1", mem_read, mem_addr, busy);
    end
    wait_ack(1'b0, cyc);
    i_req = 1'b0;
    n_checks++;
    if (cyc !== 1) begin
      n_fail++; $display("FAIL fetch_latency: got %0d more cycles want 1", cyc);
    end
    n_checks++;
    if (i_err !== 1'b0 || i_rdata !== 32'h0C00_0004) begin
      n_fail++; $display("FAIL fetch_data: got err=%b %h want 0 0c000004", i_err, i_rdata);
    end
  endtask

  task automatic test_store_load();
    int cyc;
    int wc;
    wc = write_count;
    run_d(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, cyc);
    n_checks++;
    if (cyc !== 2 || d_err !== 1'b0) begin
      n_fail++; $display("FAIL store_ack: got cyc=%0d err=%b want 2 0", cyc, d_err);
    end
    @(negedge clk);
    n_checks++;
    if (mem[64] !== 32'hDEAD_BEEF || write_count !== wc + 1) begin
      n_fail++; $display("FAIL store_mem: got %h writes=%0d want deadbeef %0d", mem[64], write_count - wc, 1);
    end
    run_d(1'b0, 32'h0000_0100, 32'h0, cyc);
    n_checks++;
    if (cyc !== 2 || d_err !== 1'b0 || d_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL load_data: got cyc=%0d err=%b %h want 2 0 deadbeef", cyc, d_err, d_rdata);
    end
  endtask

  task automatic test_contention();
    int n = 0;
    int last = 0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    for (int k = 1; k <= 40 && n < 8; k++) begin
      @(negedge clk);
      if (i_ack === 1'b1 || d_ack === 1'b1) begin
        n_checks++;
        if ({i_ack, d_ack} !== ((n % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL contention_grant%0d: got i/d ack %b want %b", n, {i_ack, d_ack}, (n % 2 == 0) ? 2'b10 : 2'b01);
        end
        n_checks++;
        if ((k - last) !== ((n == 0) ? 2 : 3)) begin
          n_fail++; $display("FAIL contention_gap%0d: got %0d want %0d", n, k - last, (n == 0) ? 2 : 3);
        end
        last = k;
        n++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    n_checks++;
    if (n !== 8) begin
      n_fail++; $display("FAIL contention_count: got %0d acks want 8", n);
    end
  endtask

  task automatic test_illegal();
    int cyc;
    int wc;
    wc = write_count;
    run_d(1'b1, 32'h0000_0010, 32'h1111_2222, cyc);
    n_checks++;
    if (cyc !== 2 || d_err !== 1'b1 || d_rdata !== 32'd0) begin
      n_fail++; $display("FAIL text_store: got cyc=%0d err=%b %h want 2 1 0", cyc, d_err, d_rdata);
    end
    run_d(1'b0, 32'h0000_0100, 32'h0, cyc);
    run_d(1'b1, 32'h0000_0402, 32'h3333_4444, cyc);
    n_checks++;
    if (cyc !== 2 || d_err !== 1'b1 || d_rdata !== 32'd0) begin
      n_fail++; $display("FAIL range_store: got cyc=%0d err=%b %h want 2 1 0", cyc, d_err, d_rdata);
    end
    run_d(1'b1, 32'h0000_007C, 32'h5555_6666, cyc);
    n_checks++;
    if (d_err !== 1'b1) begin
      n_fail++; $display("FAIL text_last_word: got err=%b want 1", d_err);
    end
    @(negedge clk);
    n_checks++;
    if (write_count !== wc || mem[4] !== 32'hA500_0004 || mem[31] !== 32'hA500_001F) begin
      n_fail++; $display("FAIL illegal_nowrite: got writes=%0d mem4=%h want 0 a5000004", write_count - wc, mem[4]);
    end
    run_d(1'b1, 32'h0000_0080, 32'h55AA_55AA, cyc);
    @(negedge clk);
    n_checks++;
    if (d_err !== 1'b0 || mem[32] !== 32'h55AA_55AA) begin
      n_fail++; $display("FAIL data_first_word: got err=%b %h want 0 55aa55aa", d_err, mem[32]);
    end
    run_d(1'b0, 32'h0000_03FC, 32'h0, cyc);
    n_checks++;
    if (d_err !== 1'b0 || d_rdata !== 32'hA500_00FF) begin
      n_fail++; $display("FAIL top_word_load: got err=%b %h want 0 a50000ff", d_err, d_rdata);
    end
    run_i(32'h0000_0005, cyc);
    n_checks++;
    if (cyc !== 2 || i_err !== 1'b1 || i_rdata !== 32'd0) begin
      n_fail++; $display("FAIL fetch_misaligned: got cyc=%0d err=%b %h want 2 1 0", cyc, i_err, i_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int wc;
    logic saw;
    logic [31:0] old;
    old = mem[128];
    wc = write_count;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_serve: got wr=%b busy=%b want 1/1", mem_write, busy);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL mid_abort: got busy=%b wr=%b want 0/0", busy, mem_write);
    end
    d_req = 1'b0; d_we = 1'b0;
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_ack === 1'b1) saw = 1'b1;
    end
    reset = 1'b0;
    @(negedge clk);
    if (d_ack === 1'b1) saw = 1'b1;
    n_checks++;
    if (saw !== 1'b0 || mem[128] !== old || write_count !== wc) begin
      n_fail++; $display("FAIL mid_nowrite: got ack=%b mem=%h want 0 %h", saw, mem[128], old);
    end
    run_i(32'h0000_0008, cyc);
    n_checks++;
    if (cyc !== 2 || i_err !== 1'b0 || i_rdata !== 32'h0C00_0004) begin
      n_fail++; $display("FAIL mid_refetch: got cyc=%0d err=%b %h want 2 0 0c000004", cyc, i_err, i_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_illegal();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
